// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Multi-cycle data-memory slave for the MEM stage. A request is accepted in
//   IDLE, waits LATENCY-1 cycles in WAIT, then completes in DONE. Memory is
//   accessed on the edge that enters DONE. The access uses the values
//   captured at acceptance.
//
// Parameters
//   BASE_ADDR  : byte address mapped to word 0
//   DEPTH_LOG2 : memory holds 2^DEPTH_LOG2 32-bit words
//   LATENCY    : edges from acceptance to completion, legal range 1..15
//
// Ports
//   clk      : rising-edge clock
//   rst      : synchronous reset, active-low
//   MEM_R_EN : read request, held until ready
//   MEM_W_EN : write request, held until ready (wins over MEM_R_EN)
//   address  : byte address
//   wdata    : write data
//   rdata    : read data, updated only when a read completes
//   ready    : one-cycle completion pulse (DONE state)
//   freeze   : pipeline stall while a request is pending and not yet done
//   err      : one-cycle pulse with ready for an illegal access
module data_mem_responder #(
    parameter int unsigned BASE_ADDR  = 1024,
    parameter int unsigned DEPTH_LOG2 = 6,
    parameter int unsigned LATENCY    = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MEM_R_EN,
    input  logic        MEM_W_EN,
    input  logic [31:0] address,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        freeze,
    output logic        err
);

    localparam logic [31:0] BASE     = 32'(BASE_ADDR);
    localparam logic [31:0] SPAN     = 32'(4) << DEPTH_LOG2;
    localparam logic [3:0]  CNT_LOAD = 4'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t              state, state_n;
    logic [3:0]          cnt, cnt_n;
    logic [31:0]         addr_q, wdata_q;
    logic                write_q, both_q;

    logic                req, capture, enter_done;
    logic [31:0]         acc_addr, acc_wdata, offset;
    logic                acc_write, acc_both, acc_legal;
    logic [DEPTH_LOG2-1:0] acc_idx;

    logic [31:0]         mem [2**DEPTH_LOG2];

    assign req    = MEM_R_EN | MEM_W_EN;
    assign ready  = (state == DONE);
    // busy_done coincides with the DONE state, so it is the same term as ready.
    assign freeze = req & ~ready;

    // With LATENCY==1 the accepting edge is also the DONE edge, before the
    // capture registers hold anything, so the live inputs bypass them.
    assign acc_addr  = capture ? address              : addr_q;
    assign acc_wdata = capture ? wdata                : wdata_q;
    assign acc_write = capture ? MEM_W_EN             : write_q;
    assign acc_both  = capture ? (MEM_W_EN & MEM_R_EN) : both_q;

    // Addresses below BASE wrap to huge offsets; the explicit lower-bound
    // test keeps this correct for any BASE placement.
    assign offset    = acc_addr - BASE;
    assign acc_legal = (acc_addr >= BASE) && (offset < SPAN) && (acc_addr[1:0] == 2'b00);
    assign acc_idx   = offset[DEPTH_LOG2+1:2];

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        capture    = 1'b0;
        enter_done = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    capture = 1'b1;
                    if (LATENCY == 1) begin
                        state_n    = DONE;
                        enter_done = 1'b1;
                    end else begin
                        state_n = WAIT;
                        cnt_n   = CNT_LOAD;
                    end
                end
            end
            WAIT: begin
                if (!req) begin
                    state_n = IDLE;
                end else if (cnt == 4'd1) begin
                    state_n    = DONE;
                    enter_done = 1'b1;
                end else begin
                    cnt_n = cnt - 4'd1;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= '0;
            rdata   <= '0;
            err     <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
            both_q  <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (capture) begin
                addr_q  <= address;
                wdata_q <= wdata;
                write_q <= MEM_W_EN;
                both_q  <= MEM_W_EN & MEM_R_EN;
            end
            err <= enter_done & (acc_both | ~acc_legal);
            if (enter_done && !acc_write) begin
                rdata <= acc_legal ? mem[acc_idx] : '0;
            end
        end
    end

    // Storage is not reset; reset only suppresses a write that would
    // otherwise complete on the same edge.
    always_ff @(posedge clk) begin
        if (rst && enter_done && acc_write && acc_legal) begin
            mem[acc_idx] <= acc_wdata;
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: a LATENCY=3 and a LATENCY=1
// instance, exercised one at a time with directed and random traffic.
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        re   [2];
    logic        we   [2];
    logic [31:0] ad   [2];
    logic [31:0] wd   [2];
    logic [31:0] rdat [2];
    logic        rdy  [2];
    logic        frz  [2];
    logic        er   [2];

    int          lat [2] = '{3, 1};
    int          cyc = 0;
    int          checks = 0;
    int          passes = 0;
    bit          in_reset = 1'b1;

    logic [31:0] model   [2][64];
    logic [31:0] last_rd [2];

    typedef struct {
        int          dut;
        int          due;
        bit          is_rd;
        logic [31:0] data;
        bit          err;
    } exp_t;
    exp_t q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    data_mem_responder #(.BASE_ADDR(1024), .DEPTH_LOG2(6), .LATENCY(3)) u_l3 (
        .clk(clk), .rst(rst), .MEM_R_EN(re[0]), .MEM_W_EN(we[0]),
        .address(ad[0]), .wdata(wd[0]), .rdata(rdat[0]),
        .ready(rdy[0]), .freeze(frz[0]), .err(er[0])
    );

    data_mem_responder #(.BASE_ADDR(1024), .DEPTH_LOG2(6), .LATENCY(1)) u_l1 (
        .clk(clk), .rst(rst), .MEM_R_EN(re[1]), .MEM_W_EN(we[1]),
        .address(ad[1]), .wdata(wd[1]), .rdata(rdat[1]),
        .ready(rdy[1]), .freeze(frz[1]), .err(er[1])
    );

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] want);
        checks++;
        if (act === want) passes++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, want, cyc);
    endfunction

    function automatic bit legal(logic [31:0] a);
        return (a >= 1024) && (a < 1024 + 64 * 4) && (a % 4 == 0);
    endfunction

    function automatic int widx(logic [31:0] a);
        return int'((a - 1024) / 4);
    endfunction

    function automatic logic [31:0] rand_addr();
        int k;
        k = $urandom_range(0, 9);
        if (k < 7)       return 32'(1024 + 4 * $urandom_range(0, 63));
        else if (k == 7) return 32'(1024 + 4 * $urandom_range(0, 63) + $urandom_range(1, 3));
        else if (k == 8) return ($urandom_range(0, 1) == 1) ? 32'(1024 - 4 * $urandom_range(1, 4))
                                                             : 32'(1024 + 256 + 4 * $urandom_range(0, 3));
        else             return $urandom;
    endfunction

    // Monitor: every cycle each DUT's outputs are compared with the scoreboard.
    always @(negedge clk) begin
        if (!in_reset) begin
            for (int d = 0; d < 2; d++) begin
                if (rdy[d]) begin
                    if (q.size() == 0 || q[0].dut != d) begin
                        chk("ready_unexpected", 32'(rdy[d]), 32'd0);
                    end else begin
                        exp_t e;
                        e = q.pop_front();
                        chk("done_cycle", cyc, e.due);
                        chk("err_on_done", 32'(er[d]), 32'(e.err));
                        if (e.is_rd) begin
                            chk("rdata", rdat[d], e.data);
                            last_rd[d] = e.data;
                        end else begin
                            chk("rdata_hold_write", rdat[d], last_rd[d]);
                        end
                    end
                end else begin
                    chk("err_idle", 32'(er[d]), 32'd0);
                    chk("rdata_hold", rdat[d], last_rd[d]);
                end
            end
        end
    end

    task automatic txn(input int d, input bit r, input bit w,
                       input logic [31:0] a, input logic [31:0] data);
        exp_t e;
        int   nf;
        bit   seen;
        @(posedge clk); #1;
        re[d] = r; we[d] = w; ad[d] = a; wd[d] = data;
        e.dut   = d;
        e.due   = cyc + lat[d];
        e.is_rd = r && !w;
        e.err   = (r && w) || !legal(a);
        e.data  = '0;
        if (w) begin
            if (legal(a)) model[d][widx(a)] = data;
        end else begin
            e.data = legal(a) ? model[d][widx(a)] : 32'd0;
        end
        q.push_back(e);
        nf = 0;
        seen = 1'b0;
        for (int i = 0; i < lat[d] + 8; i++) begin
            @(negedge clk);
            if (rdy[d]) begin
                seen = 1'b1;
                break;
            end
            if (frz[d]) nf++;
        end
        chk("ready_seen", 32'(seen), 32'd1);
        if (seen) begin
            chk("freeze_cycles", nf, lat[d]);
            chk("freeze_in_done", 32'(frz[d]), 32'd0);
        end else begin
            q.delete();
        end
    endtask

    // Write request held for h cycles, then dropped before completion.
    task automatic abort_w(input int d, input logic [31:0] a, input logic [31:0] data, input int h);
        @(posedge clk); #1;
        re[d] = 1'b0; we[d] = 1'b1; ad[d] = a; wd[d] = data;
        repeat (h) @(posedge clk);
        #1;
        re[d] = 1'b0; we[d] = 1'b0;
    endtask

    task automatic idle(input int d, input int n);
        @(posedge clk); #1;
        re[d] = 1'b0; we[d] = 1'b0;
        repeat (n - 1) @(posedge clk);
    endtask

    task automatic rand_phase(input int d, input int n);
        int          op;
        logic [31:0] a, data;
        for (int i = 0; i < n; i++) begin
            op   = $urandom_range(0, 7);
            a    = rand_addr();
            data = $urandom;
            if (op <= 2)      txn(d, 1'b1, 1'b0, a, data);
            else if (op <= 5) txn(d, 1'b0, 1'b1, a, data);
            else if (op == 6) txn(d, 1'b1, 1'b1, a, data);
            else if (lat[d] > 1) abort_w(d, a, data, $urandom_range(1, lat[d] - 1));
            else              txn(d, 1'b1, 1'b0, a, data);
            if ($urandom_range(0, 2) == 0) idle(d, $urandom_range(1, 2));
        end
        idle(d, 2);
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout: got running expected finished (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            re[d] = 1'b0; we[d] = 1'b0; ad[d] = '0; wd[d] = '0;
        end

        // Power-on reset
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("reset_ready", 32'(rdy[d]), 32'd0);
            chk("reset_err", 32'(er[d]), 32'd0);
            chk("reset_rdata", rdat[d], 32'd0);
            last_rd[d] = '0;
        end
        rst = 1'b1;
        in_reset = 1'b0;

        // Fill both memories so every later read has a defined expectation
        for (int d = 0; d < 2; d++) begin
            for (int w = 0; w < 64; w++) txn(d, 1'b0, 1'b1, 32'(1024 + 4 * w), $urandom);
            idle(d, 2);
        end

        // LATENCY=3 directed
        txn(0, 1'b0, 1'b1, 32'd1028, 32'hDEADBEEF);
        idle(0, 1);
        txn(0, 1'b1, 1'b0, 32'd1028, 32'h0);
        idle(0, 3);
        txn(0, 1'b1, 1'b0, 32'd1024, 32'h0);
        txn(0, 1'b1, 1'b0, 32'd1032, 32'h0);
        idle(0, 2);
        abort_w(0, 32'd1036, ~model[0][3], 2);
        idle(0, 2);
        txn(0, 1'b1, 1'b0, 32'd1036, 32'h0);
        idle(0, 1);
        txn(0, 1'b1, 1'b0, 32'd1020, 32'h0);
        idle(0, 1);
        txn(0, 1'b0, 1'b1, 32'd1026, 32'h12345678);
        idle(0, 1);
        txn(0, 1'b1, 1'b0, 32'd1024, 32'h0);
        idle(0, 2);

        // Reset held for two edges while a write to 1040 sits in WAIT
        @(posedge clk); #1;
        re[0] = 1'b0; we[0] = 1'b1; ad[0] = 32'd1040; wd[0] = ~model[0][4];
        @(posedge clk); #1;
        in_reset = 1'b1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("wait_reset_ready", 32'(rdy[d]), 32'd0);
            chk("wait_reset_err", 32'(er[d]), 32'd0);
            chk("wait_reset_rdata", rdat[d], 32'd0);
            last_rd[d] = '0;
        end
        we[0] = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        in_reset = 1'b0;
        txn(0, 1'b1, 1'b0, 32'd1040, 32'h0);
        idle(0, 2);

        // LATENCY=1 directed
        txn(1, 1'b1, 1'b0, 32'd1024, 32'h0);
        idle(1, 1);
        txn(1, 1'b1, 1'b1, 32'd1028, 32'hCAFEF00D);
        idle(1, 1);
        txn(1, 1'b1, 1'b0, 32'd1028, 32'h0);
        idle(1, 2);

        rand_phase(0, 150);
        rand_phase(1, 150);

        chk("scoreboard_drained", q.size(), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Multi-cycle data-memory slave answering the MEM stage's read/write strobes.
- Presents a fixed-latency handshake: `freeze` stalls the pipeline while an access is in flight, and `ready` marks the completion cycle.
- Sits between `MEM_stage` and the CPU top level as the responder end of the MEM-stage memory interface. It replaces the single-cycle `RAM` when wait states are modelled.

Parameters:
- BASE_ADDR, 1024, byte address mapped to word 0
- DEPTH_LOG2, 6, memory holds 2^DEPTH_LOG2 32-bit words
- LATENCY, 3, clock edges from request acceptance to completion; legal range 1..15

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-low (0 = reset)
- MEM_R_EN  input  1  read request, held by requester until ready
- MEM_W_EN  input  1  write request, held by requester until ready
- address  input  32  byte address (ALU result)
- wdata  input  32  write data (Val_Rm)
- rdata  output  32  read data, valid from the ready cycle, held until next read completes
- ready  output  1  one-cycle completion pulse
- freeze  output  1  stall to pipeline registers: (MEM_R_EN|MEM_W_EN) & ~ready & ~busy_done, combinational
- err  output  1  one-cycle pulse on completion of an illegal access

Behaviour:
- Reset (rst=0 at a rising edge):
  - state=IDLE, cnt=0, rdata=0, ready=0, err=0.
  - Any in-flight access is dropped and no write occurs.
  - Memory contents are NOT cleared.
- States are IDLE, WAIT and DONE. `ready` = (state==DONE).
- IDLE:
  - At an edge where MEM_R_EN|MEM_W_EN is 1: capture address, wdata and op into registers.
  - If LATENCY==1, go to DONE. Otherwise go to WAIT with cnt=LATENCY-1.
- WAIT:
  - Each edge: if the request has dropped (both enables 0), abort to IDLE with no memory update.
  - Else if cnt==1, go to DONE. Else decrement cnt.
- Entering DONE (same edge): perform the access using the captured values.
  - Word index = (addr-BASE_ADDR)>>2, using the low DEPTH_LOG2 bits.
- DONE: always returns to IDLE at the next edge. The still-asserted request of the finished instruction is ignored in that cycle.
- A new request is accepted only in IDLE. Back-to-back accesses therefore cost LATENCY+1 cycles each.
- Net timing from the first cycle the request is visible:
  - freeze is high for exactly LATENCY cycles.
  - ready is high on cycle LATENCY+1.
  - freeze is low in the DONE cycle.
- Op decode:
  - MEM_W_EN has priority. Both enables set is treated as a write and err pulses in the DONE cycle.
- Illegal address: address<BASE_ADDR, address>=BASE_ADDR+4*2^DEPTH_LOG2, or address[1:0]!=0.
  - Write: memory is unchanged.
  - Read: rdata=0.
  - Either case: err=1 in the DONE cycle. Handshake timing is unchanged.
- rdata:
  - Updated only on the edge entering DONE for reads.
  - Unchanged by writes, aborts and idle cycles.
- Requester contract: address/wdata may change after acceptance without effect, because captured values are used.
- cnt is 4 bits. It never wraps, since it is loaded only with LATENCY-1≤14 and decremented to 1.

Test Plan:
- Reset hold: rst=0 for 2 edges during a WAIT -> ready=0, err=0, rdata=0, state IDLE; a later read of the target word shows no write occurred.
- Write then read, LATENCY=3:
  - W_EN, addr=1028, wdata=0xDEADBEEF -> freeze=1 for 3 cycles, ready=1 on the 4th.
  - Then R_EN, addr=1028 -> rdata=0xDEADBEEF in its ready cycle, held afterwards.
- Back-to-back reads of 1024 and 1032 with enables held continuously -> two ready pulses 4 cycles apart; freeze=0 in each DONE cycle; second access starts the cycle after DONE.
- Abort: W_EN to 1036, dropped after 1 WAIT cycle -> no ready pulse; a subsequent read of 1036 returns the prior value.
- Illegal access: read addr=1020 -> err=1 and ready=1 in the same cycle, rdata=0. Write addr=1026 -> err=1, memory unchanged.
- LATENCY=1 build: R_EN at addr 1024 -> freeze high 1 cycle, ready on cycle 2; R_EN and W_EN together -> treated as write, err=1.
